// File: rtl/delay_timer_bank_pkg.sv
// Shared types for the delay timer bank: channel state and run mode encodings.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package delay_timer_pkg;

  typedef enum logic {ST_IDLE, ST_RUN} dt_state_e;

  typedef enum logic {MODE_ONESHOT, MODE_PERIODIC} dt_mode_e;

  // Channel-select width, never narrower than one bit.
  function automatic int chw_of(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/delay_timer_bank_if.sv
// Config write port, per-channel start/stop requests and per-channel status of the timer bank.
// Latency: n/a (wires only).
// Backpressure: none; every request is accepted in the cycle it is presented.
interface delay_timer_bank_if
  import delay_timer_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CBITS = 15,
  parameter int CHW   = chw_of(NCH)
);
  logic             cfg_we;
  logic [CHW-1:0]   cfg_ch;
  logic [CBITS-1:0] cfg_period;
  logic             cfg_mode;
  logic [NCH-1:0]   start;
  logic [NCH-1:0]   stop;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   sig;
  logic [NCH-1:0]   err;
  logic [NCH-1:0]   flg;

  modport master (
    output cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop,
    input  busy, sig, err, flg
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_period, cfg_mode, start, stop,
    output busy, sig, err, flg
  );
endinterface

// File: rtl/delay_timer_bank_chan.sv
// One delay timer channel: counts 0..act_period, flags terminal count, then re-arms or idles.
// Latency: start at t -> busy at t+1, sig at t+1+P; outputs come from registered state only.
// Backpressure: none; start/stop are level-sampled every cycle, stop wins over start.
module delay_timer_chan
  import delay_timer_pkg::*;
#(
  parameter int CBITS     = 15,
  parameter int DEFAULT_N = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [CBITS-1:0] wr_period,
  input  logic             wr_mode,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             sig,
  output logic             err,
  output logic             flg
);
  localparam logic [CBITS-1:0] DEF_P = CBITS'(DEFAULT_N);

  dt_state_e        state, state_nxt;
  logic [CBITS-1:0] cnt, cnt_nxt;
  logic [CBITS-1:0] act_period, act_period_nxt;
  logic [CBITS-1:0] pend_period, pend_period_nxt;
  dt_mode_e         act_mode, act_mode_nxt;
  dt_mode_e         pend_mode, pend_mode_nxt;
  logic             load;

  // Register channel state; reset returns to the default period and drops any pending write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      act_period  <= DEF_P;
      act_mode    <= MODE_PERIODIC;
      pend_period <= DEF_P;
      pend_mode   <= MODE_PERIODIC;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      act_period  <= act_period_nxt;
      act_mode    <= act_mode_nxt;
      pend_period <= pend_period_nxt;
      pend_mode   <= pend_mode_nxt;
    end
  end

  // Next state and counter; active config only reloads where cnt restarts at 0, so cnt never exceeds it.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    load            = 1'b0;
    busy            = 1'b0;
    sig             = 1'b0;
    flg             = 1'b0;
    err             = 1'b0;
    // A write in the same cycle as a load point is the value that gets loaded.
    pend_period_nxt = we ? wr_period : pend_period;
    pend_mode_nxt   = we ? dt_mode_e'(wr_mode) : pend_mode;

    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        load    = 1'b1;
        if (start && !stop) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (start) begin
          cnt_nxt = '0;
          load    = 1'b1;
        end else if (cnt == act_period) begin
          cnt_nxt = '0;
          load    = 1'b1;
          if (act_mode == MODE_ONESHOT) state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + CBITS'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    act_period_nxt = load ? pend_period_nxt : act_period;
    act_mode_nxt   = load ? pend_mode_nxt : act_mode;

    busy = (state == ST_RUN);
    sig  = busy && (cnt == act_period);
    flg  = busy && (cnt < act_period);
    err  = (cnt > act_period);
  end

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of NCH independent programmable delay timers sharing one config write port.
// Latency: per channel, start at t -> busy at t+1, sig at t+1+P; config to an idle channel effective at t+1.
// Backpressure: none; config writes to cfg_ch >= NCH are dropped, stop wins over start.
module delay_timer_bank
  import delay_timer_pkg::*;
#(
  parameter int NCH       = 4,
  parameter int CBITS     = 15,
  parameter int DEFAULT_N = 20000,
  parameter int CHW       = chw_of(NCH)
) (
  input logic               clk,
  input logic               rst,
  delay_timer_bank_if.slave bus
);
  logic [NCH-1:0] busy_w, sig_w, err_w, flg_w;

  if (NCH < 1) begin : g_bad_nch
    $error("delay_timer_bank: NCH must be at least 1");
  end
  if (DEFAULT_N < 0 || DEFAULT_N >= (2 ** CBITS)) begin : g_bad_default
    $error("delay_timer_bank: DEFAULT_N must fit in CBITS");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    logic we_i;

    // Unmatched channel selects produce no write enable, so out-of-range writes vanish.
    assign we_i = bus.cfg_we && (bus.cfg_ch == CHW'(i));

    delay_timer_chan #(
      .CBITS     (CBITS),
      .DEFAULT_N (DEFAULT_N)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .we        (we_i),
      .wr_period (bus.cfg_period),
      .wr_mode   (bus.cfg_mode),
      .start     (bus.start[i]),
      .stop      (bus.stop[i]),
      .busy      (busy_w[i]),
      .sig       (sig_w[i]),
      .err       (err_w[i]),
      .flg       (flg_w[i])
    );

    a_no_err:   assert property (@(posedge clk) disable iff (rst) !err_w[i]);
    a_sig_xflg: assert property (@(posedge clk) disable iff (rst) sig_w[i] |-> !flg_w[i]);
    a_busy_one: assert property (@(posedge clk) disable iff (rst) busy_w[i] |-> (sig_w[i] ^ flg_w[i]));
  end

  assign bus.busy = busy_w;
  assign bus.sig  = sig_w;
  assign bus.err  = err_w;
  assign bus.flg  = flg_w;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Self-checking bench for delay_timer_bank: timeline reference model plus directed scenario checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_delay_timer_bank;
  localparam int NCH       = 4;
  localparam int CBITS     = 15;
  localparam int DEFAULT_N = 20000;
  localparam int CHW       = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  delay_timer_bank_if #(.NCH(NCH), .CBITS(CBITS), .CHW(CHW)) bus ();

  delay_timer_bank #(
    .NCH(NCH), .CBITS(CBITS), .DEFAULT_N(DEFAULT_N), .CHW(CHW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int now     = 0;
  int o_cyc   = 0;

  // next inputs to present; pulses are cleared after each tick
  logic             d_rst;
  logic             d_we;
  logic [CHW-1:0]   d_ch;
  logic [CBITS-1:0] d_per;
  logic             d_mode;
  logic [NCH-1:0]   d_start;
  logic [NCH-1:0]   d_stop;

  logic [NCH-1:0] o_busy, o_sig, o_flg, o_err;

  // reference model: each running channel is described by the cycle its current period began
  int m_run   [NCH];
  int m_t0    [NCH];
  int m_per   [NCH];
  int m_mode  [NCH];
  int m_pper  [NCH];
  int m_pmode [NCH];

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_run[i]   = 0;
      m_t0[i]    = 0;
      m_per[i]   = DEFAULT_N;
      m_mode[i]  = 1;
      m_pper[i]  = DEFAULT_N;
      m_pmode[i] = 1;
    end
  endtask

  task automatic model_step();
    if (d_rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (d_we && int'(d_ch) == i) begin
          m_pper[i]  = int'(d_per);
          m_pmode[i] = int'(d_mode);
        end
        if (m_run[i] == 0) begin
          m_per[i]  = m_pper[i];
          m_mode[i] = m_pmode[i];
          if (d_start[i] && !d_stop[i]) begin
            m_run[i] = 1;
            m_t0[i]  = now + 1;
          end
        end else if (d_stop[i]) begin
          m_run[i] = 0;
        end else if (d_start[i]) begin
          m_per[i]  = m_pper[i];
          m_mode[i] = m_pmode[i];
          m_t0[i]   = now + 1;
        end else if (now - m_t0[i] == m_per[i]) begin
          if (m_mode[i] == 1) begin
            m_t0[i]   = now + 1;
            m_per[i]  = m_pper[i];
            m_mode[i] = m_pmode[i];
          end else begin
            m_run[i] = 0;
          end
        end
      end
    end
  endtask

  // one clock cycle: observe and compare against the model, then present the next inputs
  task automatic tick();
    logic [NCH-1:0] eb, es, ef;
    @(negedge clk);
    o_cyc  = now;
    o_busy = bus.busy;
    o_sig  = bus.sig;
    o_flg  = bus.flg;
    o_err  = bus.err;
    for (int i = 0; i < NCH; i++) begin
      eb[i] = (m_run[i] != 0);
      es[i] = (m_run[i] != 0) && (now - m_t0[i] == m_per[i]);
      ef[i] = (m_run[i] != 0) && (now - m_t0[i] <  m_per[i]);
    end
    n_tests++;
    if ({o_busy, o_sig, o_flg, o_err} !== {eb, es, ef, {NCH{1'b0}}}) begin
      n_fail++;
      $display("FAIL model_cmp cyc=%0d got busy=%b sig=%b flg=%b err=%b expected busy=%b sig=%b flg=%b err=%b",
               now, o_busy, o_sig, o_flg, o_err, eb, es, ef, {NCH{1'b0}});
    end
    rst            = d_rst;
    bus.cfg_we     = d_we;
    bus.cfg_ch     = d_ch;
    bus.cfg_period = d_per;
    bus.cfg_mode   = d_mode;
    bus.start      = d_start;
    bus.stop       = d_stop;
    model_step();
    now++;
    d_rst   = 1'b0;
    d_we    = 1'b0;
    d_start = '0;
    d_stop  = '0;
  endtask

  task automatic test_reset();
    d_rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({o_busy, o_sig, o_flg, o_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%h expected=0", {o_busy, o_sig, o_flg, o_err});
    end
  endtask

  task automatic test_default_period();
    int t, s1, s2;
    s1 = -1;
    s2 = -1;
    d_start = NCH'(1);
    t = now;
    tick();
    repeat (40010) begin
      tick();
      if (o_sig[0]) begin
        if (s1 < 0) s1 = o_cyc;
        else if (s2 < 0) s2 = o_cyc;
      end
    end
    n_tests++;
    if (s1 != t + 1 + DEFAULT_N) begin
      n_fail++;
      $display("FAIL default_first_sig got=%0d expected=%0d", s1, t + 1 + DEFAULT_N);
    end
    n_tests++;
    if (s2 != t + 2 + 2 * DEFAULT_N) begin
      n_fail++;
      $display("FAIL default_second_sig got=%0d expected=%0d", s2, t + 2 + 2 * DEFAULT_N);
    end
    d_stop = NCH'(1);
    tick();
    tick();
    n_tests++;
    if (o_busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL default_stop_busy got=%b expected=0", o_busy[0]);
    end
  endtask

  task automatic test_oneshot();
    int t, nflg, nsig, sig_at, busy_t5;
    nflg = 0; nsig = 0; sig_at = -1; busy_t5 = -1;
    d_we = 1'b1; d_ch = 2'd1; d_per = CBITS'(3); d_mode = 1'b0;
    tick();
    d_start = NCH'(2);
    t = now;
    tick();
    repeat (12) begin
      tick();
      if (o_flg[1]) nflg++;
      if (o_sig[1]) begin nsig++; sig_at = o_cyc; end
      if (o_cyc == t + 5) busy_t5 = int'(o_busy[1]);
    end
    n_tests++;
    if (nflg != 3) begin n_fail++; $display("FAIL oneshot_flg_count got=%0d expected=3", nflg); end
    n_tests++;
    if (nsig != 1) begin n_fail++; $display("FAIL oneshot_sig_count got=%0d expected=1", nsig); end
    n_tests++;
    if (sig_at != t + 4) begin n_fail++; $display("FAIL oneshot_sig_cycle got=%0d expected=%0d", sig_at, t + 4); end
    n_tests++;
    if (busy_t5 != 0) begin n_fail++; $display("FAIL oneshot_busy_after got=%0d expected=0", busy_t5); end
  endtask

  task automatic test_midrun_write();
    int t;
    int sigs[$];
    d_we = 1'b1; d_ch = 2'd2; d_per = CBITS'(10); d_mode = 1'b1;
    tick();
    d_start = NCH'(4);
    t = now;
    tick();
    repeat (20) begin
      if (now == t + 6) begin
        d_we = 1'b1; d_ch = 2'd2; d_per = CBITS'(2); d_mode = 1'b1;
      end
      tick();
      if (o_sig[2]) sigs.push_back(o_cyc);
    end
    n_tests++;
    if (sigs.size() < 3) begin
      n_fail++;
      $display("FAIL midrun_sig_count got=%0d expected>=3", sigs.size());
    end else begin
      n_tests++;
      if (sigs[0] != t + 11) begin n_fail++; $display("FAIL midrun_sig0 got=%0d expected=%0d", sigs[0], t + 11); end
      n_tests++;
      if (sigs[1] != t + 14) begin n_fail++; $display("FAIL midrun_sig1 got=%0d expected=%0d", sigs[1], t + 14); end
      n_tests++;
      if (sigs[2] != t + 17) begin n_fail++; $display("FAIL midrun_sig2 got=%0d expected=%0d", sigs[2], t + 17); end
    end
    d_stop = NCH'(4);
    tick();
  endtask

  task automatic test_start_stop();
    int t, first;
    first = -1;
    d_we = 1'b1; d_ch = 2'd3; d_per = CBITS'(4); d_mode = 1'b1;
    tick();
    d_start = NCH'(8);
    tick();
    tick();
    tick();
    d_start = NCH'(8);
    d_stop  = NCH'(8);
    tick();
    tick();
    n_tests++;
    if ({o_busy[3], o_sig[3], o_flg[3]} !== 3'b000) begin
      n_fail++;
      $display("FAIL startstop_idle got busy/sig/flg=%b expected=000", {o_busy[3], o_sig[3], o_flg[3]});
    end
    d_start = NCH'(8);
    t = now;
    tick();
    repeat (8) begin
      tick();
      if (o_sig[3] && first < 0) first = o_cyc;
    end
    n_tests++;
    if (first != t + 5) begin
      n_fail++;
      $display("FAIL startstop_restart_sig got=%0d expected=%0d", first, t + 5);
    end
    d_stop = NCH'(8);
    tick();
  endtask

  task automatic test_rst_midcount();
    int t, first;
    first = -1;
    d_we = 1'b1; d_ch = 2'd0; d_per = CBITS'(9); d_mode = 1'b1;
    tick();
    d_start = '1;
    tick();
    repeat (5) tick();
    d_we = 1'b1; d_ch = 2'd3; d_per = CBITS'(7); d_mode = 1'b0;
    tick();
    d_rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({o_busy, o_sig, o_flg} !== '0) begin
      n_fail++;
      $display("FAIL rst_midcount_idle got busy=%b sig=%b flg=%b expected all 0", o_busy, o_sig, o_flg);
    end
    d_start = NCH'(8);
    t = now;
    tick();
    repeat (DEFAULT_N + 4) begin
      tick();
      if (o_sig[3] && first < 0) first = o_cyc;
    end
    n_tests++;
    if (first != t + 1 + DEFAULT_N) begin
      n_fail++;
      $display("FAIL rst_default_period got=%0d expected=%0d", first, t + 1 + DEFAULT_N);
    end
    d_stop = '1;
    tick();
  endtask

  task automatic test_period0();
    int t, nsig, nflg, busy_t2;
    nsig = 0; nflg = 0; busy_t2 = -1;
    d_we = 1'b1; d_ch = 2'd0; d_per = '0; d_mode = 1'b1;
    tick();
    d_start = NCH'(1);
    tick();
    repeat (10) begin
      tick();
      if (o_sig[0]) nsig++;
      if (o_flg[0]) nflg++;
    end
    n_tests++;
    if (nsig != 10) begin n_fail++; $display("FAIL p0_periodic_sig got=%0d expected=10", nsig); end
    n_tests++;
    if (nflg != 0) begin n_fail++; $display("FAIL p0_periodic_flg got=%0d expected=0", nflg); end
    d_stop = NCH'(1);
    tick();
    d_we = 1'b1; d_ch = 2'd0; d_per = '0; d_mode = 1'b0;
    tick();
    nsig = 0;
    d_start = NCH'(1);
    t = now;
    tick();
    repeat (5) begin
      tick();
      if (o_sig[0]) nsig++;
      if (o_cyc == t + 2) busy_t2 = int'(o_busy[0]);
    end
    n_tests++;
    if (nsig != 1) begin n_fail++; $display("FAIL p0_oneshot_sig got=%0d expected=1", nsig); end
    n_tests++;
    if (busy_t2 != 0) begin n_fail++; $display("FAIL p0_oneshot_busy got=%0d expected=0", busy_t2); end
  endtask

  task automatic test_random();
    repeat (4000) begin
      for (int i = 0; i < NCH; i++) begin
        d_start[i] = ($urandom_range(0, 15) == 0);
        d_stop[i]  = ($urandom_range(0, 31) == 0);
      end
      if ($urandom_range(0, 7) == 0) begin
        d_we   = 1'b1;
        d_ch   = CHW'($urandom_range(0, NCH - 1));
        d_per  = CBITS'($urandom_range(0, 12));
        d_mode = 1'($urandom_range(0, 1));
      end
      d_rst = ($urandom_range(0, 999) == 0);
      tick();
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_ch     = '0;
    bus.cfg_period = '0;
    bus.cfg_mode   = 1'b0;
    bus.start      = '0;
    bus.stop       = '0;
    d_rst = 1'b0; d_we = 1'b0; d_ch = '0; d_per = '0; d_mode = 1'b0;
    d_start = '0; d_stop = '0;
    model_reset();
    repeat (2) @(posedge clk);

    test_reset();
    test_default_period();
    test_oneshot();
    test_midrun_write();
    test_start_stop();
    test_rst_midcount();
    test_period0();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
